seq_mult_16: RTL and testbench

//  Iterative shift-and-add 16x16->32 multiplier for the ALU MULT/MULTU path.

---
 rtl/seq_mult_16_pkg.sv | 23 ++
 rtl/seq_mult_16_if.sv | 24 ++
 rtl/Adder_16bits.sv | 13 +
 rtl/seq_mult_16.sv | 110 +++++++++++
 tb/tb_seq_mult_16.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/seq_mult_16_pkg.sv
// Shared definitions for the seq_mult_16 iterative multiplier.
// Optional signed support is enabled with the SEQ_MULT_SIGNED_EN macro.
package seq_mult_16_pkg;

    localparam int unsigned MULT_WIDTH = 16;
    localparam int unsigned MULT_ITER  = 16;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned PROD_W     = 2 * MULT_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Magnitude of a two's-complement operand; -32768 maps to 0x8000, which
    // is still a valid unsigned magnitude.
    function automatic logic [MULT_WIDTH-1:0] abs16(input logic [MULT_WIDTH-1:0] x);
        return x[MULT_WIDTH-1] ? MULT_WIDTH'(~x + MULT_WIDTH'(1)) : x;
    endfunction

endpackage

// File: rtl/seq_mult_16_if.sv
// Request/response bundle for seq_mult_16.
// is_signed exists only when SEQ_MULT_SIGNED_EN is defined.
interface seq_mult_16_if;
    import seq_mult_16_pkg::*;

    logic                  start;
    logic [MULT_WIDTH-1:0] a;
    logic [MULT_WIDTH-1:0] b;
`ifdef SEQ_MULT_SIGNED_EN
    logic                  is_signed;
`endif
    logic                  busy;
    logic                  done;
    logic [PROD_W-1:0]     product;

`ifdef SEQ_MULT_SIGNED_EN
    modport master (output start, a, b, is_signed, input busy, done, product);
    modport slave  (input start, a, b, is_signed, output busy, done, product);
`else
    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
`endif

endinterface

// File: rtl/Adder_16bits.sv
// 16-bit ripple adder: {G,S} = A + B + C; G is the carry-out.
module Adder_16bits (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        C,
    output logic [15:0] S,
    output logic        G
);

    // Full-width sum with the carry-out in the top bit
    assign {G, S} = 17'(A) + 17'(B) + 17'(C);

endmodule

// File: rtl/seq_mult_16.sv
// Iterative shift-and-add 16x16->32 multiplier with start/busy/done handshake.
// Define SEQ_MULT_SIGNED_EN to add the is_signed input and a sign fix-up state
// (latency 18 instead of 17).
module seq_mult_16
    import seq_mult_16_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    seq_mult_16_if.slave  bus
);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    // High half of the partial product; the carry bit of the 17-bit
    // accumulator is always zero right after the shift, so it is not stored.
    logic [MULT_WIDTH-1:0] acc;
    logic [MULT_WIDTH-1:0] mq;
    logic [MULT_WIDTH-1:0] mcand;
`ifdef SEQ_MULT_SIGNED_EN
    logic                  neg;
`endif

    logic [MULT_WIDTH-1:0] add_b;
    logic [MULT_WIDTH-1:0] sum;
    logic                  cout;

    // Addend selected by the current multiplier LSB
    assign add_b = mq[0] ? mcand : '0;

    Adder_16bits u_adder (
        .A (acc),
        .B (add_b),
        .C (1'b0),
        .S (sum),
        .G (cout)
    );

    // Control FSM, shift registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            acc         <= '0;
            mq          <= '0;
            mcand       <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            neg         <= 1'b0;
`endif
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.product <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
`ifdef SEQ_MULT_SIGNED_EN
                        if (bus.is_signed) begin
                            mcand <= abs16(bus.a);
                            mq    <= abs16(bus.b);
                            neg   <= bus.a[MULT_WIDTH-1] ^ bus.b[MULT_WIDTH-1];
                        end else begin
                            mcand <= bus.a;
                            mq    <= bus.b;
                            neg   <= 1'b0;
                        end
`else
                        mcand <= bus.a;
                        mq    <= bus.b;
`endif
                        acc      <= '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    // {carry, sum, mq} shifted right by one
                    {acc, mq} <= {cout, sum, mq[MULT_WIDTH-1:1]};
                    cnt       <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(MULT_ITER - 1)) begin
`ifdef SEQ_MULT_SIGNED_EN
                        state <= ST_FIX;
`else
                        state <= ST_DONE;
`endif
                    end
                end
`ifdef SEQ_MULT_SIGNED_EN
                ST_FIX: begin
                    if (neg) begin
                        {acc, mq} <= PROD_W'(~{acc, mq} + PROD_W'(1));
                    end
                    state <= ST_DONE;
                end
`endif
                ST_DONE: begin
                    bus.product <= {acc, mq};
                    bus.done    <= 1'b1;
                    bus.busy    <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_16.sv
// Self-checking bench for seq_mult_16 (honours SEQ_MULT_SIGNED_EN).
module tb_seq_mult_16;
    import seq_mult_16_pkg::*;

`ifdef SEQ_MULT_SIGNED_EN
    localparam int LAT = 18;
`else
    localparam int LAT = 17;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_mult_16_if bus ();

    seq_mult_16 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic product, wrapped to 32 bits
    function automatic logic [31:0] ref_prod(input logic [15:0] x, input logic [15:0] y,
                                             input logic sg);
        int sx;
        int sy;
        if (sg) begin
            sx = int'($signed(x));
            sy = int'($signed(y));
            return 32'(sx * sy);
        end
        return {16'd0, x} * {16'd0, y};
    endfunction

    // One multiply: checks busy/done every cycle, latency, product and hold
    task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic sg, input int repulse_at);
        logic [31:0] exp_p;
        exp_p = ref_prod(x, y, sg);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
`ifdef SEQ_MULT_SIGNED_EN
        bus.is_signed = sg;
`endif
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 16'($urandom);
        bus.b     = 16'($urandom);
`ifdef SEQ_MULT_SIGNED_EN
        bus.is_signed = 1'($urandom);
`endif
        for (int k = 0; k <= LAT; k++) begin
            @(negedge clk);
            check({tag, "_busy_done"}, {30'd0, bus.busy, bus.done},
                  {30'd0, (k < LAT), (k == LAT)});
            if (k == LAT) check({tag, "_product"}, bus.product, exp_p);
            if (k == repulse_at) begin
                bus.start = 1'b1;
                bus.a     = 16'd7;
                bus.b     = 16'd7;
            end else begin
                bus.start = 1'b0;
            end
        end
        @(negedge clk);
        check({tag, "_idle_after"}, {30'd0, bus.busy, bus.done}, 32'd0);
        check({tag, "_hold"}, bus.product, exp_p);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
`ifdef SEQ_MULT_SIGNED_EN
        bus.is_signed = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
        check("reset_product", bus.product, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_no_start", {30'd0, bus.busy, bus.done}, 32'd0);

        run_op("3x5", 16'd3, 16'd5, 1'b0, -1);
        run_op("ffff_sq", 16'hFFFF, 16'hFFFF, 1'b0, -1);
        check("ffff_sq_const", bus.product, 32'hFFFE0001);
        run_op("zero", 16'd0, 16'h1234, 1'b0, -1);
        run_op("repulse", 16'd11, 16'd13, 1'b0, 5);
        check("repulse_const", bus.product, 32'd143);

        // Reset in the middle of an operation
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h1111;
        bus.b     = 16'h2222;
`ifdef SEQ_MULT_SIGNED_EN
        bus.is_signed = 1'b0;
`endif
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int k = 0; k < 8; k++) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
        check("midrst_product", bus.product, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_rst", 16'd2, 16'd9, 1'b0, -1);
        check("after_rst_const", bus.product, 32'h12);

`ifdef SEQ_MULT_SIGNED_EN
        run_op("s_m3x5", 16'hFFFD, 16'd5, 1'b1, -1);
        check("s_m3x5_const", bus.product, 32'hFFFFFFF1);
        run_op("s_min_sq", 16'h8000, 16'h8000, 1'b1, -1);
        check("s_min_sq_const", bus.product, 32'h40000000);
        run_op("u_ffff_sq", 16'hFFFF, 16'hFFFF, 1'b0, -1);
        run_op("s_min_x_1", 16'h8000, 16'd1, 1'b1, -1);
`endif

        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
`ifdef SEQ_MULT_SIGNED_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            if (i == 0) ra = 16'h8000;
            if (i == 1) rb = 16'hFFFF;
            run_op("random", ra, rb, rs, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
